timer_mc: RTL and testbench
===========================

# timer_mc

Multi-channel, parametrised timer/counter for the SoC peripheral bus. One shared prescaled counter supports free-run, auto-reload and one-shot modes and drives CHANNELS independent compare units. Each compare unit produces a single-cycle tick, a sticky pending flag and a maskable interrupt contribution. The block sits behind the peripheral register file, which supplies all configuration inputs as static register values.

## Interface
- WIDTH, 32: counter, period and compare width (2..32)
- CHANNELS, 4: number of compare channels (1..8)
- PSC_WIDTH, 16: prescaler width
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- clr_i  in  1  synchronous clear: counter, prescaler, done, pending, ticks
- ena_i  in  1  count enable; low freezes prescaler and counter
- mode_i  in  2  00 free-run, 01 auto-reload, 10 one-shot, 11 treated as 00
- psc_i  in  PSC_WIDTH  divide value; counter advances every psc_i+1 enabled cycles
- period_i  in  WIDTH  terminal value for modes 01/10; ignored in 00
- cmp_value_i  in  CHANNELS*WIDTH  channel c compare at [c*WIDTH +: WIDTH]
- irq_en_i  in  CHANNELS  per-channel interrupt enable
- irq_clr_i  in  CHANNELS  write-1-to-clear pending, one-cycle pulse
- value_o  out  WIDTH  counter value
- tick_o  out  CHANNELS  one-cycle match pulse
- pending_o  out  CHANNELS  sticky match flags
- ovf_o  out  1  one-cycle wrap/reload pulse
- done_o  out  1  one-shot finished, sticky
- irq_o  out  1  |(pending_o & irq_en_i), registered

## Operation
- Priority each cycle: rst_i > clr_i > normal operation.
- Prescaler psc_cnt (PSC_WIDTH): when ena_i=1, adv = (psc_cnt >= psc_i); psc_cnt <= adv ? 0 : psc_cnt+1. `>=` makes lowering psc_i mid-count safe.
- adv is suppressed while done_o=1.
- On adv:
  - Free-run: value <= value+1, modulo 2^WIDTH. ovf_o pulses when wrapping from all-ones to 0.
  - Auto-reload: if value >= period_i, value <= 0 and ovf_o pulses; otherwise value+1. Sequence is 0..period_i, which is period_i+1 states.
  - One-shot: if value >= period_i, value holds and done_o <= 1; otherwise value+1.
- done_o clears only on clr_i or rst_i. Changing mode_i does not clear it.
- Match for channel c: on an adv cycle whose next counter value equals cmp_c, tick_o[c] is registered high for exactly one cycle, aligned with value_o first showing cmp_c.
  - Held counter values never re-tick. This covers prescaled holds, ena_i low, and the one-shot halt.
- Pending: pending_o[c] sets on tick and clears on irq_clr_i[c]. If tick and clear occur in the same cycle, set wins.
- irq_o is registered from pending_o & irq_en_i, so it lags pending_o by one cycle.
- Configuration inputs may change at any time and take effect on the next adv.

## Timing
- Reset values: value_o=0, tick_o=0, pending_o=0, ovf_o=0, done_o=0, irq_o=0, psc_cnt=0.
- clr_i behaves the same as reset, but synchronously, and overrides a simultaneous adv, tick or set.
- psc_i=0, ena_i=1: value_o increments every cycle. psc_i=N: value_o changes every N+1 enabled cycles.
- First adv after reset: value_o goes 0->1 at the (psc_i+1)-th enabled edge.
- Any cmp_c=0 ticks only when the counter enters 0 by wrap/reload. There is no tick for the reset value.
- One-shot with period_i=0: the first adv sets done_o, value_o stays 0, and no tick occurs.
- Latency: tick_o and value_o update on the same edge. pending_o follows tick_o by 1 cycle. irq_o follows pending_o by 1 cycle.

## Test plan
- Free-run, WIDTH=8, psc_i=0, cmp0=3: after reset, ena_i=1.
  - value_o = 1,2,3,…; tick_o[0] high only in the cycle value_o=3.
  - pending_o[0] high the next cycle; irq_o one cycle later with irq_en_i[0]=1.
  - value_o wraps 255->0 with ovf_o pulse.
- Prescale psc_i=2, cmp1=2: value_o changes every 3 cycles. tick_o[1] is high for 1 cycle, not 3.
- Auto-reload, period_i=4:
  - value_o = 0,1,2,3,4,0,1… with ovf_o on each 4->0 transition.
  - Lowering period_i to 2 while value_o=3 reloads to 0 on the next adv.
- One-shot, period_i=5, cmp2=5:
  - value_o stops at 5, done_o=1, tick_o[2] exactly once.
  - Holding ena_i=1 for 20 more cycles produces no further ticks.
  - clr_i restarts the count from 0.
- Pending race: irq_clr_i[0] asserted in the same cycle as tick_o[0] leaves pending_o[0]=1. A clear on a later cycle drops pending_o[0] and then irq_o.
- Asynchronous rst_i mid-count (value_o=7, pending=0xF) zeroes all outputs immediately. A clr_i concurrent with a match suppresses the tick.

Source files
------------

// File: rtl/timer_mc.sv
// Multi-channel timer: one shared prescaled counter (free-run / auto-reload /
// one-shot) feeding CHANNELS compare units with tick, sticky pending and irq.

module timer_mc_ch #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             moved_i,
  input  logic [WIDTH-1:0] nxt_i,
  input  logic [WIDTH-1:0] cmp_i,
  input  logic             irq_clr_i,
  output logic             tick_o,
  output logic             pending_o
);
  logic tick_q, tick_d, pend_q, pend_d;

  // Only a real counter transition can match; held values never re-tick.
  assign tick_d = moved_i && (nxt_i == cmp_i);
  // A tick landing with a clear wins.
  assign pend_d = (pend_q & ~irq_clr_i) | tick_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_q <= 1'b0;
      pend_q <= 1'b0;
    end else if (clr_i) begin
      tick_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
      pend_q <= pend_d;
    end
  end

  assign tick_o    = tick_q;
  assign pending_o = pend_q;
endmodule

module timer_mc #(
  parameter int WIDTH     = 32,
  parameter int CHANNELS  = 4,
  parameter int PSC_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clr_i,
  input  logic                      ena_i,
  input  logic [1:0]                mode_i,
  input  logic [PSC_WIDTH-1:0]      psc_i,
  input  logic [WIDTH-1:0]          period_i,
  input  logic [CHANNELS*WIDTH-1:0] cmp_value_i,
  input  logic [CHANNELS-1:0]       irq_en_i,
  input  logic [CHANNELS-1:0]       irq_clr_i,
  output logic [WIDTH-1:0]          value_o,
  output logic [CHANNELS-1:0]       tick_o,
  output logic [CHANNELS-1:0]       pending_o,
  output logic                      ovf_o,
  output logic                      done_o,
  output logic                      irq_o
);
  logic [PSC_WIDTH-1:0] psc_q, psc_d;
  logic [WIDTH-1:0]     value_q, value_d;
  logic                 ovf_q, ovf_d, done_q, done_d, irq_q, irq_d;
  logic                 psc_hit, adv, at_term, moved;

  always_comb begin
    psc_hit = (psc_q >= psc_i);
    adv     = ena_i & psc_hit & ~done_q;
    at_term = (value_q >= period_i);
    psc_d   = psc_q;
    if (ena_i) psc_d = psc_hit ? '0 : psc_q + 1'b1;
    value_d = value_q;
    ovf_d   = 1'b0;
    done_d  = done_q;
    moved   = 1'b0;
    if (adv) begin
      unique case (mode_i)
        2'b01: begin
          moved = 1'b1;
          if (at_term) begin
            value_d = '0;
            ovf_d   = 1'b1;
          end else begin
            value_d = value_q + 1'b1;
          end
        end
        2'b10: begin
          // Terminal value reached: hold and latch done.
          if (at_term) begin
            done_d = 1'b1;
          end else begin
            value_d = value_q + 1'b1;
            moved   = 1'b1;
          end
        end
        default: begin
          moved   = 1'b1;
          value_d = value_q + 1'b1;
          ovf_d   = &value_q;
        end
      endcase
    end
    irq_d = |(pending_o & irq_en_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      psc_q   <= '0;
      value_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else if (clr_i) begin
      psc_q   <= '0;
      value_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      psc_q   <= psc_d;
      value_q <= value_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      irq_q   <= irq_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    timer_mc_ch #(.WIDTH(WIDTH)) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (clr_i),
      .moved_i   (moved),
      .nxt_i     (value_d),
      .cmp_i     (cmp_value_i[c*WIDTH +: WIDTH]),
      .irq_clr_i (irq_clr_i[c]),
      .tick_o    (tick_o[c]),
      .pending_o (pending_o[c])
    );
  end

  assign value_o = value_q;
  assign ovf_o   = ovf_q;
  assign done_o  = done_q;
  assign irq_o   = irq_q;
endmodule

// File: tb/tb_timer_mc.sv
// Bench for timer_mc: directed test-plan scenarios plus random stimulus, all
// checked each cycle against an arithmetic model of the counter rules.

module tb_timer_mc;
  localparam int W = 8, CH = 4, PW = 4;

  logic            clk_i = 1'b0, rst_i = 1'b1, clr_i = 1'b0, ena_i = 1'b0;
  logic [1:0]      mode_i = 2'b00;
  logic [PW-1:0]   psc_i = '0;
  logic [W-1:0]    period_i = '0;
  logic [CH*W-1:0] cmp_value_i;
  logic [CH-1:0]   irq_en_i = '1, irq_clr_i = '0;
  logic [W-1:0]    value_o;
  logic [CH-1:0]   tick_o, pending_o;
  logic            ovf_o, done_o, irq_o;

  int total = 0, bad = 0;
  int m_val, m_psc, m_cmp[CH];
  logic [CH-1:0] m_tick, m_pend;
  bit  m_ovf, m_done, m_irq;

  timer_mc #(.WIDTH(W), .CHANNELS(CH), .PSC_WIDTH(PW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .ena_i(ena_i), .mode_i(mode_i),
    .psc_i(psc_i), .period_i(period_i), .cmp_value_i(cmp_value_i),
    .irq_en_i(irq_en_i), .irq_clr_i(irq_clr_i), .value_o(value_o), .tick_o(tick_o),
    .pending_o(pending_o), .ovf_o(ovf_o), .done_o(done_o), .irq_o(irq_o));

  always #5 clk_i = ~clk_i;

  task automatic set_cmp(input int c3, input int c2, input int c1, input int c0);
    m_cmp[0] = c0; m_cmp[1] = c1; m_cmp[2] = c2; m_cmp[3] = c3;
    for (int c = 0; c < CH; c++) cmp_value_i[c*W +: W] = W'(m_cmp[c]);
  endtask

  task automatic m_zero();
    m_val = 0; m_psc = 0; m_tick = '0; m_pend = '0;
    m_ovf = 0; m_done = 0; m_irq = 0;
  endtask

  // One clock of the timer's rules, applied to the inputs held across the edge.
  task automatic model();
    int nv;
    bit adv, moved;
    logic [CH-1:0] nt;
    if (clr_i) begin m_zero(); return; end
    adv = ena_i && !m_done && (m_psc >= int'(psc_i));
    if (ena_i) m_psc = (m_psc >= int'(psc_i)) ? 0 : (m_psc + 1) % (1 << PW);
    m_irq  = |(m_pend & irq_en_i);
    m_pend = (m_pend & ~irq_clr_i) | m_tick;
    m_ovf = 0; moved = 0; nv = m_val; nt = '0;
    if (adv) begin
      if (mode_i == 2'b01) begin
        moved = 1;
        if (m_val >= int'(period_i)) begin nv = 0; m_ovf = 1; end
        else nv = m_val + 1;
      end else if (mode_i == 2'b10) begin
        if (m_val >= int'(period_i)) m_done = 1;
        else begin nv = m_val + 1; moved = 1; end
      end else begin
        moved = 1;
        nv = (m_val + 1) % (1 << W);
        m_ovf = (m_val == (1 << W) - 1);
      end
    end
    for (int c = 0; c < CH; c++) nt[c] = moved && (nv == m_cmp[c]);
    m_tick = nt;
    m_val  = nv;
  endtask

  task automatic step();
    @(posedge clk_i);
    model();
    @(negedge clk_i);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic lit(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      total++;
      if ({value_o, tick_o, pending_o, ovf_o, done_o, irq_o} !==
          {W'(m_val), m_tick, m_pend, m_ovf, m_done, m_irq}) begin
        bad++;
        $display("FAIL cycle t=%0t: got v=%0d tk=%h pd=%h ov=%b dn=%b irq=%b expected v=%0d tk=%h pd=%h ov=%b dn=%b irq=%b",
                 $time, value_o, tick_o, pending_o, ovf_o, done_o, irq_o,
                 m_val, m_tick, m_pend, m_ovf, m_done, m_irq);
      end
    end
  end

  initial begin
    int cnt;
    set_cmp(200, 5, 2, 3);
    m_zero();
    #12;
    lit("reset value", int'(value_o), 0);
    lit("reset flags", int'({tick_o, pending_o, ovf_o, done_o, irq_o}), 0);
    @(negedge clk_i); rst_i = 1'b0; #1;

    // Free-run, psc 0
    ena_i = 1'b1;
    steps(3);
    lit("fr value3", int'(value_o), 3);
    lit("fr tick0", int'(tick_o[0]), 1);
    step();
    lit("fr pend0", int'(pending_o[0]), 1);
    lit("fr tick0 once", int'(tick_o[0]), 0);
    step();
    lit("fr irq", int'(irq_o), 1);
    steps(250);
    lit("fr value255", int'(value_o), 255);
    step();
    lit("fr wrap value", int'(value_o), 0);
    lit("fr wrap ovf", int'(ovf_o), 1);

    // Pending race: clear lands with the tick, set wins
    irq_en_i = 4'b0001;
    steps(3);
    irq_clr_i = 4'b0001;
    step();
    irq_clr_i = '0;
    lit("race pend0", int'(pending_o[0]), 1);
    step();
    irq_clr_i = 4'b0001;
    step();
    irq_clr_i = '0;
    lit("clr pend0", int'(pending_o[0]), 0);
    lit("clr irq lags", int'(irq_o), 1);
    step();
    lit("clr irq", int'(irq_o), 0);

    // Prescale psc 2
    clr_i = 1'b1; step(); clr_i = 1'b0;
    psc_i = 4'd2;
    steps(5);
    lit("psc value1", int'(value_o), 1);
    step();
    lit("psc value2", int'(value_o), 2);
    lit("psc tick1", int'(tick_o[1]), 1);
    step();
    lit("psc tick1 once", int'(tick_o[1]), 0);

    // Auto-reload period 4, then lowered to 2 at value 3
    clr_i = 1'b1; step(); clr_i = 1'b0;
    psc_i = '0; mode_i = 2'b01; period_i = 8'd4;
    steps(5);
    lit("ar reload", int'(value_o), 0);
    lit("ar ovf", int'(ovf_o), 1);
    steps(3);
    period_i = 8'd2;
    step();
    lit("ar lowered reload", int'(value_o), 0);
    lit("ar lowered ovf", int'(ovf_o), 1);

    // One-shot period 5
    clr_i = 1'b1; step(); clr_i = 1'b0;
    mode_i = 2'b10; period_i = 8'd5;
    steps(5);
    lit("os value5", int'(value_o), 5);
    lit("os tick2", int'(tick_o[2]), 1);
    step();
    lit("os done", int'(done_o), 1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin step(); cnt += int'(tick_o[2]); end
    lit("os no retick", cnt, 0);
    lit("os held", int'(value_o), 5);
    clr_i = 1'b1; step(); clr_i = 1'b0;
    lit("os clr done", int'(done_o), 0);
    step();
    lit("os restart", int'(value_o), 1);

    // Async reset mid-count
    clr_i = 1'b1; step(); clr_i = 1'b0;
    mode_i = 2'b00; set_cmp(4, 3, 2, 1);
    steps(7);
    lit("pre-rst value", int'(value_o), 7);
    lit("pre-rst pend", int'(pending_o), 15);
    #1 rst_i = 1'b1; m_zero();
    #1;
    lit("async rst value", int'(value_o), 0);
    lit("async rst flags", int'({tick_o, pending_o, ovf_o, done_o, irq_o}), 0);
    #1 rst_i = 1'b0;

    // Clear coinciding with a match
    set_cmp(200, 5, 2, 3);
    steps(2);
    lit("pre-clr value", int'(value_o), 2);
    clr_i = 1'b1; step(); clr_i = 1'b0;
    lit("clr kills tick", int'(tick_o[0]), 0);
    lit("clr value", int'(value_o), 0);

    // Random traffic against the model
    irq_en_i = '1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 60 == 0) begin
        mode_i   = 2'($urandom_range(0, 3));
        psc_i    = PW'($urandom_range(0, 3));
        period_i = ($urandom_range(0, 7) == 0) ? W'($urandom_range(1, 255))
                                               : W'($urandom_range(1, 12));
        set_cmp($urandom_range(0, 12), $urandom_range(0, 12),
                $urandom_range(0, 12), $urandom_range(0, 12));
        irq_en_i = CH'($urandom);
      end
      ena_i     = ($urandom_range(0, 9) < 8);
      clr_i     = ($urandom_range(0, 79) == 0);
      irq_clr_i = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '0;
      step();
    end
    clr_i = 1'b0; irq_clr_i = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
